// File: rtl/ialu_ctrl_seq_pkg.sv
// Shared decode constants, ALU control codes and sequencer state encodings
// for the integer ALU control sequencer.
package ialu_ctrl_seq_pkg;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_LOAD_FP  = 5'b00001;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_STORE_FP = 5'b01001;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_MUL   = 3'b001,
    ALU_DIV   = 3'b010,
    ALU_SLT   = 3'b011,
    ALU_LOGIC = 3'b100,
    ALU_SHIFT = 3'b101,
    ALU_BR    = 3'b110,
    ALU_NOP   = 3'b111
  } alu_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  typedef struct packed {
    alu_code_e code;
    logic      sub;
    logic      idiv;
    logic      bubble;
  } dec_t;

  // Funct3 grouping shared by register-register and immediate integer ops.
  function automatic alu_code_e f3_map(input logic [2:0] f3);
    case (f3)
      3'b000:         return ALU_ADD;
      3'b001, 3'b101: return ALU_SHIFT;
      3'b010, 3'b011: return ALU_SLT;
      default:        return ALU_LOGIC;
    endcase
  endfunction

endpackage

// File: rtl/ialu_ctrl_seq_if.sv
// ID-stage to execute-stage control bus: decode fields in, registered ALU
// control out, plus the divider start/done/abort side channel.
interface ialu_ctrl_seq_if #(
  parameter int ALU_CTRL_W = 3
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7_5;
  logic                  funct7_0;
  logic                  en_pc;
  logic                  undef_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic                  sub;
  logic                  idiv;
  logic                  div_start;
  logic                  div_done;
  logic                  div_abort;
  logic                  busy;

  modport master (
    output flush, in_valid, opcode, funct3, funct7_5, funct7_0, en_pc,
           undef_instr, out_ready, div_done,
    input  in_ready, out_valid, alu_ctrl, sub, idiv, div_start, div_abort, busy
  );

  modport slave (
    input  flush, in_valid, opcode, funct3, funct7_5, funct7_0, en_pc,
           undef_instr, out_ready, div_done,
    output in_ready, out_valid, alu_ctrl, sub, idiv, div_start, div_abort, busy
  );
endinterface

// File: rtl/ialu_ctrl_seq_decode.sv
// Pure combinational RV32IM decode of instruction fields into ALU code,
// subtract select, divide-class flag and bubble indication. No state, no stall.
module ialu_ctrl_seq_decode
  import ialu_ctrl_seq_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       funct7_0,
  input  logic       en_pc,
  input  logic       undef_instr,
  output dec_t       dec
);

  always_comb begin
    dec.code   = ALU_NOP;
    dec.sub    = 1'b0;
    dec.idiv   = 1'b0;
    dec.bubble = 1'b0;
    if (undef_instr || !en_pc) begin
      dec.bubble = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          dec.sub = funct7_5;
          if (funct7_0) begin
            if (funct3[2]) begin
              dec.code = ALU_DIV;
              dec.idiv = 1'b1;
            end else begin
              dec.code = ALU_MUL;
            end
          end else begin
            dec.code = f3_map(funct3);
          end
        end
        OPC_OP_IMM: dec.code = f3_map(funct3);
        OPC_BRANCH: dec.code = ALU_BR;
        OPC_LOAD, OPC_LOAD_FP, OPC_STORE, OPC_STORE_FP,
        OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC: dec.code = ALU_ADD;
        default: dec.code = ALU_NOP;
      endcase
    end
  end

endmodule

// File: rtl/ialu_ctrl_seq.sv
// Registered ALU control issue with valid/ready, 1-cycle latency; divides hold
// decode off (in_ready=0) from start pulse until completion, timeout or flush.
module ialu_ctrl_seq
  import ialu_ctrl_seq_pkg::*;
#(
  parameter int ALU_CTRL_W   = 3,
  parameter int DIV_CYCLES   = 32,
  parameter int DIV_EXT_DONE = 0,
  parameter int DIV_TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  ialu_ctrl_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD     = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  out_valid_q;
  logic [ALU_CTRL_W-1:0] alu_ctrl_q;
  logic                  sub_q;
  logic                  idiv_q;
  logic                  div_start_q;
  logic                  div_abort_q;
  logic                  busy_q;
  dec_t                  dec;
  logic                  accept;

  ialu_ctrl_seq_decode u_decode (
    .opcode      (bus.opcode),
    .funct3      (bus.funct3),
    .funct7_5    (bus.funct7_5),
    .funct7_0    (bus.funct7_0),
    .en_pc       (bus.en_pc),
    .undef_instr (bus.undef_instr),
    .dec         (dec)
  );

  assign bus.in_ready  = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.alu_ctrl  = alu_ctrl_q;
  assign bus.sub       = sub_q;
  assign bus.idiv      = idiv_q;
  assign bus.div_start = div_start_q;
  assign bus.div_abort = div_abort_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= ALU_CTRL_W'(ALU_NOP);
      sub_q       <= 1'b0;
      idiv_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      div_abort_q <= 1'b0;
      // Flush beats any accept or divider event in the same cycle.
      if (bus.flush) begin
        state       <= ST_IDLE;
        cnt         <= '0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              alu_ctrl_q <= ALU_CTRL_W'(dec.code);
              sub_q      <= dec.sub;
              idiv_q     <= dec.idiv;
              if (dec.bubble) begin
                out_valid_q <= 1'b0;
              end else if (dec.idiv) begin
                out_valid_q <= 1'b0;
                div_start_q <= 1'b1;
                busy_q      <= 1'b1;
                state       <= ST_DIV;
                cnt         <= (DIV_EXT_DONE != 0) ? '0 : CNT_LOAD;
              end else begin
                out_valid_q <= 1'b1;
              end
            end else if (bus.out_ready) begin
              out_valid_q <= 1'b0;
            end
          end
          ST_DIV: begin
            if (DIV_EXT_DONE != 0) begin
              // Completion takes priority over a timeout landing the same cycle.
              if (bus.div_done) begin
                out_valid_q <= 1'b1;
                state       <= ST_HOLD;
                cnt         <= '0;
              end else if (cnt == TIMEOUT_LAST) begin
                div_abort_q <= 1'b1;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                state       <= ST_IDLE;
                cnt         <= '0;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end else begin
              if (cnt == '0) begin
                out_valid_q <= 1'b1;
                state       <= ST_HOLD;
              end else begin
                cnt <= cnt - CNT_ONE;
              end
            end
          end
          ST_HOLD: begin
            if (bus.out_ready) begin
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          default: begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt         <= '0;
          end
        endcase
      end
    end
  end

endmodule
